// File: rtl/commit_trace_queue_pkg.sv
// Shared types and constants for the commit trace queue: the trace entry
// layout, the ebreak encoding and default sizing.
package trace_pkg;

    localparam int unsigned TRACE_XLEN      = 64;
    localparam int unsigned DEF_DEPTH       = 4;
    localparam int unsigned DEF_WDOG_CYCLES = 4096;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef struct packed {
        logic [31:0]           inst;
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] dnpc;
    } trace_entry_t;

    function automatic logic is_ebreak(input logic [31:0] inst);
        return inst == EBREAK_INST;
    endfunction

endpackage

// File: rtl/commit_trace_queue_if.sv
// Writeback-side and sink-side handshake bundle of the commit trace queue.
// The queue takes the slave view; the writeback stage / sink take the master view.
interface commit_trace_queue_if #(
    parameter int unsigned XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_dnpc;

    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_inst;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_dnpc;

    modport master (
        output in_valid, in_inst, in_pc, in_dnpc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_dnpc
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_dnpc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_dnpc
    );
endinterface

// File: rtl/commit_trace_queue_fifo.sv
// Synchronous FIFO of trace entries with registered storage, wrap-around
// pointers and an occupancy count one bit wider than the pointers.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  trace_entry_t wdata_i,
    input  logic         pop_i,
    output trace_entry_t rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    trace_entry_t  mem_q [DEPTH];
    trace_entry_t  mem_d [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        full_o  = (count_q == (PW+1)'(DEPTH));
        empty_o = (count_q == '0);
        rdata_o = mem_q[rd_ptr_q];
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; stale contents are masked by count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/commit_trace_queue.sv
// Commit trace queue: buffers retired instructions for the trace sink and
// tracks retire count, ebreak halt and a commit watchdog.
module commit_trace_queue
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned XLEN        = TRACE_XLEN,
    parameter int unsigned WDOG_CYCLES = DEF_WDOG_CYCLES
) (
    input  logic                 clock,
    input  logic                 reset,
    commit_trace_queue_if.slave  tq,
    output logic [63:0]          retire_cnt,
    output logic                 halted,
    output logic                 wdog_timeout
);
    localparam int unsigned IW = $clog2(WDOG_CYCLES) + 1;
    localparam logic [IW-1:0] IDLE_LAST = IW'(WDOG_CYCLES - 1);

    if (XLEN != TRACE_XLEN) begin : g_xlen_check
        $error("commit_trace_queue: XLEN must match trace_pkg::TRACE_XLEN");
    end

    logic          ready_en_q, ready_en_d;
    logic          halted_q, halted_d;
    logic          wdog_q, wdog_d;
    logic [63:0]   retire_q, retire_d;
    logic [IW-1:0] idle_q, idle_d;

    logic          fifo_full, fifo_empty;
    logic          in_ready, out_valid, push, pop;
    trace_entry_t  wr_entry, head;

    // in_ready depends only on registered state, never on out_ready.
    always_comb begin
        in_ready  = ready_en_q & ~fifo_full & ~halted_q;
        out_valid = ~fifo_empty & ~halted_q;
        push      = tq.in_valid & in_ready;
        pop       = out_valid & tq.out_ready;

        wr_entry.inst = tq.in_inst;
        wr_entry.pc   = tq.in_pc;
        wr_entry.dnpc = tq.in_dnpc;

        tq.in_ready  = in_ready;
        tq.out_valid = out_valid;
        tq.out_inst  = head.inst;
        tq.out_pc    = head.pc;
        tq.out_dnpc  = head.dnpc;
    end

    trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset),
        .push_i  (push),
        .wdata_i (wr_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        ready_en_d = 1'b1;
        retire_d   = retire_q + 64'(pop);
        halted_d   = halted_q | (pop & is_ebreak(head.inst));
        idle_d     = idle_q;
        wdog_d     = wdog_q;
        if (pop) begin
            idle_d = '0;
        end else if (!halted_q && !wdog_q) begin
            if (idle_q == IDLE_LAST) begin
                wdog_d = 1'b1;
            end
            idle_d = idle_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_en_q <= 1'b0;
            halted_q   <= 1'b0;
            wdog_q     <= 1'b0;
            retire_q   <= '0;
            idle_q     <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            halted_q   <= halted_d;
            wdog_q     <= wdog_d;
            retire_q   <= retire_d;
            idle_q     <= idle_d;
        end
    end

    always_comb begin
        retire_cnt   = retire_q;
        halted       = halted_q;
        wdog_timeout = wdog_q;
    end

endmodule

// File: tb/tb_commit_trace_queue.sv
// Directed bench for commit_trace_queue: a default instance for queue, halt and
// reset behaviour, and a short-watchdog instance for timeout timing.
module tb_commit_trace_queue;

    localparam logic [31:0] ADDI   = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [63:0] BASE   = 64'h0000_0000_8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;
    logic [63:0] retire_cnt, retire_cnt2;
    logic halted, halted2, wdog, wdog2;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    commit_trace_queue_if #(.XLEN(64)) tif ();
    commit_trace_queue_if #(.XLEN(64)) tif2 ();

    commit_trace_queue #(
        .DEPTH       (4),
        .XLEN        (64),
        .WDOG_CYCLES (4096)
    ) dut (
        .clock        (clk),
        .reset        (rst_n),
        .tq           (tif),
        .retire_cnt   (retire_cnt),
        .halted       (halted),
        .wdog_timeout (wdog)
    );

    commit_trace_queue #(
        .DEPTH       (4),
        .XLEN        (64),
        .WDOG_CYCLES (16)
    ) dut_wd (
        .clock        (clk),
        .reset        (rst2_n),
        .tq           (tif2),
        .retire_cnt   (retire_cnt2),
        .halted       (halted2),
        .wdog_timeout (wdog2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc);
        tif.in_valid = 1'b1;
        tif.in_inst  = inst;
        tif.in_pc    = pc;
        tif.in_dnpc  = pc + 64'd4;
    endtask

    task automatic do_reset();
        tif.in_valid  = 1'b0;
        tif.out_ready = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        tif.in_valid   = 1'b0; tif.in_inst  = '0; tif.in_pc  = '0; tif.in_dnpc  = '0; tif.out_ready  = 1'b0;
        tif2.in_valid  = 1'b0; tif2.in_inst = '0; tif2.in_pc = '0; tif2.in_dnpc = '0; tif2.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_in_ready", tif.in_ready, 0);
        chk("rst_out_valid", tif.out_valid, 0);
        chk("rst_retire", retire_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_wdog", wdog, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_in_ready", tif.in_ready, 1);

        // Single push, latency one
        tif.out_ready = 1'b1;
        drive(ADDI, BASE);
        step();
        tif.in_valid = 1'b0;
        chk("single_valid", tif.out_valid, 1);
        chk("single_inst", tif.out_inst, ADDI);
        chk("single_pc", tif.out_pc, BASE);
        chk("single_dnpc", tif.out_dnpc, BASE + 64'd4);
        step();
        chk("single_drained", tif.out_valid, 0);
        chk("single_retire", retire_cnt, 1);

        // Fill to full with sink stalled, then drain in order
        do_reset();
        tif.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(ADDI, BASE + 64'(4 * i));
            step();
        end
        chk("full_in_ready", tif.in_ready, 0);
        drive(ADDI, BASE + 64'd16);
        step();
        chk("full_hold_ready", tif.in_ready, 0);
        chk("full_head_pc", tif.out_pc, BASE);
        tif.out_ready = 1'b1;
        #1;
        chk("full_no_bypass", tif.in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            chk("drain_valid", tif.out_valid, 1);
            chk("drain_pc", tif.out_pc, BASE + 64'(4 * k));
            step();
            if (k == 1) tif.in_valid = 1'b0;
            if (k == 3) chk("drain_retire4", retire_cnt, 4);
        end
        chk("drain_empty", tif.out_valid, 0);
        chk("drain_retire5", retire_cnt, 5);

        // Steady stream, 100 entries
        do_reset();
        tif.out_ready = 1'b1;
        for (int n = 0; n < 100; n++) begin
            drive(ADDI, BASE + 64'(4 * n));
            step();
            chk("stream_pc", tif.out_pc, BASE + 64'(4 * n));
        end
        tif.in_valid = 1'b0;
        step();
        chk("stream_retire", retire_cnt, 100);
        chk("stream_empty", tif.out_valid, 0);

        // Ebreak halt
        do_reset();
        tif.out_ready = 1'b1;
        drive(ADDI, BASE);
        step();
        drive(EBREAK, BASE + 64'd4);
        step();
        chk("halt_head_ebreak", tif.out_inst, EBREAK);
        chk("halt_not_yet", halted, 0);
        drive(ADDI, BASE + 64'd8);
        step();
        tif.in_valid = 1'b0;
        chk("halt_set", halted, 1);
        chk("halt_retire", retire_cnt, 2);
        chk("halt_out_valid", tif.out_valid, 0);
        chk("halt_in_ready", tif.in_ready, 0);
        step();
        step();
        chk("halt_frozen_valid", tif.out_valid, 0);
        chk("halt_frozen_retire", retire_cnt, 2);

        // Watchdog, no traffic: cycle 0 begins at release
        rst2_n = 1'b1;
        chk("wd_c0", wdog2, 0);
        repeat (15) step();
        chk("wd_c15", wdog2, 0);
        step();
        chk("wd_c16", wdog2, 1);
        tif2.in_valid = 1'b1; tif2.in_inst = ADDI; tif2.in_pc = BASE + 64'h40; tif2.in_dnpc = BASE + 64'h44;
        step();
        tif2.in_valid = 1'b0;
        chk("wd_queue_live_valid", tif2.out_valid, 1);
        chk("wd_queue_live_pc", tif2.out_pc, BASE + 64'h40);
        step();
        chk("wd_queue_live_retire", retire_cnt2, 1);
        chk("wd_sticky", wdog2, 1);

        // Watchdog with a pop on edge 10
        rst2_n = 1'b0;
        step();
        rst2_n = 1'b1;
        repeat (8) step();
        tif2.in_valid = 1'b1; tif2.in_inst = ADDI; tif2.in_pc = BASE; tif2.in_dnpc = BASE + 64'd4;
        step();
        tif2.in_valid = 1'b0;
        step();
        chk("wd2_pop_retire", retire_cnt2, 1);
        repeat (15) step();
        chk("wd2_c25", wdog2, 0);
        step();
        chk("wd2_c26", wdog2, 1);

        // Asynchronous reset mid-stream
        do_reset();
        tif.out_ready = 1'b1;
        drive(ADDI, BASE);
        step();
        tif.in_valid = 1'b0;
        step();
        chk("mid_pre_retire", retire_cnt, 1);
        tif.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(ADDI, BASE + 64'h100 + 64'(4 * i));
            step();
        end
        tif.in_valid = 1'b0;
        chk("mid_queued_valid", tif.out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", tif.out_valid, 0);
        chk("mid_async_retire", retire_cnt, 0);
        chk("mid_async_ready", tif.in_ready, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_post_ready", tif.in_ready, 1);
        chk("mid_no_stale", tif.out_valid, 0);
        tif.out_ready = 1'b1;
        drive(ADDI, BASE + 64'h200);
        step();
        tif.in_valid = 1'b0;
        chk("mid_new_valid", tif.out_valid, 1);
        chk("mid_new_pc", tif.out_pc, BASE + 64'h200);
        step();
        chk("mid_new_empty", tif.out_valid, 0);
        chk("mid_new_retire", retire_cnt, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
